// File: rtl/ads_mv_display.sv
// Signed ADC code to millivolt magnitude, iterative BCD conversion, multiplexed 4-digit 7-seg driver.
// Latency: sample accepted at E0, digits and neg committed at E13 (12 double-dabble steps + commit).
// Backpressure: none; a sample arriving mid-conversion is parked in a one-deep, newest-wins buffer.
module ads_mv_display #(
    parameter int SHIFT    = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_data,
    input  logic        sample_valid,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        neg
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t        state, state_nxt;
    logic [27:0]   sr, sr_nxt;             // {bcd[15:0], bin[11:0]}
    logic [3:0]    iter, iter_nxt;
    logic          cur_neg, cur_neg_nxt;
    logic [15:0]   pend_dat, pend_dat_nxt;
    logic          pend_vld, pend_vld_nxt;
    logic [15:0]   digits, digits_nxt;
    logic          neg_nxt;
    logic          load_en;
    logic [15:0]   load_code;
    logic [16:0]   load_mag;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    scan_idx;
    logic [3:0]    cur_digit;
    logic          cur_blank;

    // 17-bit magnitude so that -32768 becomes +32768 before the shift
    function automatic logic [16:0] mag_of(input logic [15:0] code);
        logic [16:0] ext;
        logic [16:0] abs_v;
        ext   = {code[15], code};
        abs_v = code[15] ? (~ext + 17'd1) : ext;
        return abs_v >> SHIFT;
    endfunction

    // One double-dabble step: correct every BCD nibble >= 5, then shift the whole register left
    function automatic logic [27:0] dabble_step(input logic [27:0] v);
        logic [27:0] a;
        a = v;
        for (int i = 0; i < 4; i++) begin
            if (a[12 + 4*i +: 4] >= 4'd5)
                a[12 + 4*i +: 4] = a[12 + 4*i +: 4] + 4'd3;
        end
        return {a[26:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Next-state, conversion datapath, pending buffer and commit
    always_comb begin
        state_nxt    = state;
        sr_nxt       = sr;
        iter_nxt     = iter;
        cur_neg_nxt  = cur_neg;
        pend_dat_nxt = pend_dat;
        pend_vld_nxt = pend_vld;
        digits_nxt   = digits;
        neg_nxt      = neg;
        load_en      = 1'b0;
        load_code    = sample_data;
        case (state)
            IDLE: begin
                if (sample_valid) load_en = 1'b1;
            end
            CONVERT: begin
                sr_nxt   = dabble_step(sr);
                iter_nxt = iter + 4'd1;
                if (iter == 4'd11) state_nxt = UPDATE;
                if (sample_valid) begin
                    pend_dat_nxt = sample_data;
                    pend_vld_nxt = 1'b1;
                end
            end
            UPDATE: begin
                digits_nxt   = sr[27:12];
                neg_nxt      = cur_neg;
                // a live strobe is newer than anything parked, so the parked sample is dropped
                pend_vld_nxt = 1'b0;
                if (sample_valid) begin
                    load_en = 1'b1;
                end else if (pend_vld) begin
                    load_en   = 1'b1;
                    load_code = pend_dat;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        load_mag = mag_of(load_code);
        if (load_en) begin
            sr_nxt      = {16'd0, load_mag[11:0]};
            iter_nxt    = 4'd0;
            cur_neg_nxt = load_code[15] && (load_mag != 17'd0);
            state_nxt   = CONVERT;
        end
    end

    // Digit for the current scan slot, taken from the post-commit digit values, with leading-zero blanking
    always_comb begin
        cur_digit = digits_nxt[4*scan_idx +: 4];
        cur_blank = 1'b0;
        case (scan_idx)
            2'd3: cur_blank = (digits_nxt[15:12] == 4'd0);
            2'd2: cur_blank = (digits_nxt[15:8] == 8'd0);
            2'd1: cur_blank = (digits_nxt[15:4] == 12'd0);
            default: cur_blank = 1'b0;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            iter     <= '0;
            cur_neg  <= 1'b0;
            pend_dat <= '0;
            pend_vld <= 1'b0;
            digits   <= '0;
            scan_cnt <= '0;
            scan_idx <= '0;
            busy     <= 1'b0;
            an       <= 4'b1111;
            seg      <= 7'b1111111;
            dp       <= 1'b1;
            neg      <= 1'b0;
        end else begin
            state    <= state_nxt;
            sr       <= sr_nxt;
            iter     <= iter_nxt;
            cur_neg  <= cur_neg_nxt;
            pend_dat <= pend_dat_nxt;
            pend_vld <= pend_vld_nxt;
            digits   <= digits_nxt;
            if (scan_cnt == CW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                scan_idx <= scan_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + CW'(1);
            end
            busy     <= (state_nxt != IDLE);
            an       <= ~(4'b0001 << scan_idx);
            seg      <= cur_blank ? 7'b1111111 : seg_of(cur_digit);
            dp       <= 1'b1;
            neg      <= neg_nxt;
        end
    end

endmodule

// File: tb/tb_ads_mv_display.sv
// Randomised and directed bench for ads_mv_display against an arithmetic reference model.
// Latency: checks commit at E13 and chained commit at E26.
// Backpressure: exercises the newest-wins pending buffer.
module tb_ads_mv_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = 16'd0;
    logic        busy, dp, neg;
    logic [3:0]  an;
    logic [6:0]  seg;

    int tests = 0;
    int fails = 0;
    int cur_val = 0;
    logic [6:0] disp [4];
    bit         an_ok;
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    ads_mv_display #(.SHIFT(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .sample_data(sample_data), .sample_valid(sample_valid),
        .busy(busy), .an(an), .seg(seg), .dp(dp), .neg(neg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_val(input logic [15:0] code);
        int c;
        c = int'($signed(code));
        if (c < 0) c = -c;
        return c / 16;
    endfunction

    function automatic logic ref_neg(input logic [15:0] code);
        return (int'($signed(code)) < 0) && (ref_val(code) != 0);
    endfunction

    function automatic int slot_of(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Expected cathodes for digit position k (0 = units) of value v
    function automatic logic [6:0] exp_seg(input int v, input int k);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (k > 0 && v < p) return 7'b1111111;
        return seg_tab[(v / p) % 10];
    endfunction

    // Capture what each digit slot shows over one full scan period
    task automatic read_display();
        int s;
        an_ok = 1'b1;
        for (int i = 0; i < 4; i++) disp[i] = 7'bx;
        for (int i = 0; i < 16; i++) begin
            tick();
            s = slot_of(an);
            if (s < 0) an_ok = 1'b0;
            else disp[s] = seg;
        end
    endtask

    task automatic test_reset();
        logic [3:0] ea;
        logic [6:0] es;
        rst = 1'b1;
        tick(); tick();
        tests++; if (an !== 4'b1111) begin fails++; $display("FAIL reset_an got=%b exp=1111", an); end
        tests++; if (seg !== 7'b1111111) begin fails++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
        tests++; if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp got=%b exp=1", dp); end
        tests++; if (neg !== 1'b0) begin fails++; $display("FAIL reset_neg got=%b exp=0", neg); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            ea = ~(4'b0001 << ((i / 4) % 4));
            es = (i < 4 || (i >= 16)) ? 7'b1000000 : 7'b1111111;
            tests++; if (an !== ea) begin fails++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", i, an, ea); end
            tests++; if (seg !== es) begin fails++; $display("FAIL scan_seg cyc=%0d got=%b exp=%b", i, seg, es); end
        end
        tests++; if (dp !== 1'b1 || neg !== 1'b0 || busy !== 1'b0)
            begin fails++; $display("FAIL idle_flags got dp=%b neg=%b busy=%b exp 1 0 0", dp, neg, busy); end
        cur_val = 0;
    endtask

    task automatic test_sample(input logic [15:0] code);
        int n;
        int s;
        sample_data  = code;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        cur_val = ref_val(code);
        tests++; if (n != 13) begin fails++; $display("FAIL busy_len code=%h got=%0d exp=13", code, n); end
        tests++; if (neg !== ref_neg(code)) begin fails++; $display("FAIL neg code=%h got=%b exp=%b", code, neg, ref_neg(code)); end
        s = slot_of(an);
        tests++; if (s < 0 || seg !== exp_seg(cur_val, (s < 0) ? 0 : s))
            begin fails++; $display("FAIL commit_slot code=%h an=%b got=%b", code, an, seg); end
        read_display();
        tests++; if (!an_ok) begin fails++; $display("FAIL an_onehot code=%h last an=%b", code, an); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (disp[k] !== exp_seg(cur_val, k))
                begin fails++; $display("FAIL digit%0d code=%h got=%b exp=%b", k, code, disp[k], exp_seg(cur_val, k)); end
        end
    endtask

    task automatic test_sign_cases();
        test_sample(16'h7FFF);
        test_sample(16'h8000);
        test_sample(16'hFFF0);
        test_sample(16'hFFFF);
        test_sample(16'h0064);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) test_sample(16'($urandom));
    endtask

    task automatic test_back_to_back();
        int prev;
        int ev;
        int s;
        prev = cur_val;
        sample_data  = 16'h0100;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_e0 got=%b exp=1", busy); end
        for (int e = 1; e <= 26; e++) begin
            if (e == 3) begin sample_data = 16'h0200; sample_valid = 1'b1; end
            if (e == 5) begin sample_data = 16'h0300; sample_valid = 1'b1; end
            tick();
            sample_valid = 1'b0;
            ev = (e < 13) ? prev : ((e < 26) ? 16 : 48);
            s  = slot_of(an);
            tests++; if (s < 0 || seg !== exp_seg(ev, (s < 0) ? 0 : s))
                begin fails++; $display("FAIL b2b_seg e=%0d an=%b got=%b exp_val=%0d", e, an, seg, ev); end
            tests++; if (busy !== (e < 26))
                begin fails++; $display("FAIL b2b_busy e=%0d got=%b exp=%b", e, busy, (e < 26)); end
        end
        cur_val = 48;
        tests++; if (neg !== 1'b0) begin fails++; $display("FAIL b2b_neg got=%b exp=0", neg); end
        read_display();
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (disp[k] !== exp_seg(48, k))
                begin fails++; $display("FAIL b2b_digit%0d got=%b exp=%b", k, disp[k], exp_seg(48, k)); end
        end
    endtask

    task automatic test_reset_mid();
        int s;
        sample_data  = 16'h7FFF;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        tests++; if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || neg !== 1'b0 || busy !== 1'b0)
            begin fails++; $display("FAIL midrst_outs got an=%b seg=%b dp=%b neg=%b busy=%b", an, seg, dp, neg, busy); end
        rst = 1'b0;
        cur_val = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            s = slot_of(an);
            tests++; if (busy !== 1'b0 || s < 0 || seg !== exp_seg(0, (s < 0) ? 0 : s))
                begin fails++; $display("FAIL midrst_idle cyc=%0d an=%b seg=%b busy=%b", i, an, seg, busy); end
        end
        test_sample(16'h0010);
    endtask

    initial begin
        test_reset();
        test_sign_cases();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ads_mv_display.md
# ads_mv_display

Downstream consumer of the ADS1115 I2C reader. It takes each 16-bit signed conversion result plus a one-cycle valid strobe and converts it to a millivolt magnitude for PGA ±2.048 V (1 LSB = 62.5 µV, so mV = code/16). It converts that magnitude to 4-digit BCD with an iterative double-dabble engine. It drives a multiplexed, active-low 4-digit seven-segment display and a sign LED.

## Interface
- `SHIFT`, default 4: right-shift from code magnitude to mV; 4 matches ±2.048 V.
- `SCAN_DIV`, default 50000: clk cycles per digit slot; 1 kHz digit rate at 50 MHz.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `sample_data` in 16: two's-complement conversion result.
- `sample_valid` in 1: single-cycle strobe; `sample_data` is valid in the same cycle.
- `busy` out 1: high while state != IDLE.
- `an` out 4: digit enables, active-low; `an[0]` = units, `an[3]` = thousands.
- `seg` out 7: cathodes, active-low, bit order {g,f,e,d,c,b,a}.
- `dp` out 1: decimal point, active-low; held 1 (off).
- `neg` out 1: sign LED, active-high.

## Operation
- Magnitude:
  - mag = (code < 0 ? −code : code) >> SHIFT, computed in 17 bits so that −32768 yields 32768.
  - With SHIFT=4, mag is 0..2048 and only the low 12 bits are used.
  - Truncation is toward zero.
- Sign: `neg` = code[15] AND mag != 0. Negative zero is displayed as positive 0.
- FSM states: IDLE, CONVERT, UPDATE.
  - IDLE, `sample_valid`=1: latch mag and sign, load the shift register {bcd16=0, bin12=mag}, clear the iteration counter, go to CONVERT.
  - CONVERT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. After the 12th iteration, go to UPDATE.
  - UPDATE: commit bcd to the display digit registers and the sign to `neg`. Next state:
    - `sample_valid`=1 this cycle: load that sample, go to CONVERT.
    - else if pending is set: load the pending sample, clear pending, go to CONVERT.
    - else: go to IDLE.
- Pending buffer (one-deep):
  - `sample_valid` during CONVERT overwrites the pending register and sets the pending flag.
  - Only the newest sample is kept; older samples are dropped silently.
- Leading-zero blanking:
  - Thousands blanked if 0.
  - Hundreds blanked if thousands and hundreds are both 0.
  - Tens blanked if the three upper digits are all 0.
  - Units is never blanked. A blanked digit drives `seg`=7'b1111111.
- Scan:
  - The scan counter counts 0..SCAN_DIV−1. On wrap, the digit index advances 0→1→2→3→0.
  - Exactly one `an` bit is low at a time.
  - `seg` always shows the digit registers, so a commit appears on the current slot immediately.
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

## Timing
- All outputs are registered.
- Reset values:
  - Outputs: `an`=4'b1111, `seg`=7'b1111111, `dp`=1, `neg`=0, `busy`=0.
  - Internal: digit registers=0, pending=0, scan index=0, scan counter=0, state=IDLE.
- First edge after `rst` deasserts: `an`=4'b1110, `seg`=1000000, showing "0".
- Latency, with the sample accepted at edge E0:
  - CONVERT iterations occur at edges E1..E12.
  - Commit occurs at E13: new digits and `neg` are visible on the outputs after E13.
  - `busy` is high after E0 through E13, or continuously if another conversion is chained.
- Chained sample: CONVERT restarts at E13, and its commit lands at E26.
- `rst` mid-conversion: the conversion is aborted, pending is cleared, and all outputs return to reset values on that edge. No partial value is ever committed.

## Test plan
- Reset, SCAN_DIV=4:
  - Required after release: `an` cycles 1110→1101→1011→0111 every 4 clk.
  - `seg`=1000000 on the `an[0]` slot and 1111111 on all other slots; `neg`=0, `busy`=0, `dp`=1.
- `sample_data`=16'h7FFF:
  - Required: after E13, digits 2,0,4,7 and `neg`=0.
  - Required: `busy` is high for exactly 13 cycles.
- `sample_data`=16'h8000:
  - Required: displays 2048 and `neg`=1.
  - Required: the units slot shows `seg`=0000000.
- Sign edge cases:
  - 16'hFFF0: displays 1, `neg`=1.
  - 16'hFFFF: displays 0, `neg`=0.
  - 16'h0064: displays 6, with `an[3:1]` slots blanked.
- Back-to-back samples, valid strobes at E0=16'h0100, E3=16'h0200, E5=16'h0300:
  - Required: commit 16 at E13, then commit 48 at E26.
  - Required: 32 is never displayed, and `busy` stays high from after E0 through E26.
- Reset during conversion: 16'h7FFF at E0, then `rst` at E6.
  - Required: outputs return to reset values, and no 2047 commit ever appears.
  - Then 16'h0010 sent: displays 1 after 13 cycles.
